// File: rtl/cpu19_mc_core.sv
// cpu19_mc_core: multi-cycle CPU, 19-bit instructions, own imem/dmem/stack.
// Define CPU19_MULDIV_EN to implement MUL/DIV; otherwise they are illegal.
module cpu19_mc_core #(
   parameter int DW          = 16,
   parameter int IMEM_AW     = 8,
   parameter int DMEM_AW     = 8,
   parameter int STACK_DEPTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic               imem_we,
   input  logic [IMEM_AW-1:0] imem_waddr,
   input  logic [18:0]        imem_wdata,
   input  logic [3:0]         dbg_addr,
   output logic [DW-1:0]      dbg_data,
   output logic [IMEM_AW-1:0] pc_o,
   output logic               retired,
   output logic               halted,
   output logic               fault,
   output logic [1:0]         fault_code
);
   localparam int SPW = $clog2(STACK_DEPTH) + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_MEM   = 3'd3;
   localparam logic [2:0] S_MEM2  = 3'd4;
   localparam logic [2:0] S_HALT  = 3'd5;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_MUL  = 5'b00010;
   localparam logic [4:0] OP_DIV  = 5'b00011;
   localparam logic [4:0] OP_INC  = 5'b00100;
   localparam logic [4:0] OP_DEC  = 5'b00101;
   localparam logic [4:0] OP_AND  = 5'b00110;
   localparam logic [4:0] OP_OR   = 5'b00111;
   localparam logic [4:0] OP_XOR  = 5'b01000;
   localparam logic [4:0] OP_NOT  = 5'b01001;
   localparam logic [4:0] OP_JMP  = 5'b01010;
   localparam logic [4:0] OP_BEQ  = 5'b01011;
   localparam logic [4:0] OP_BNE  = 5'b01100;
   localparam logic [4:0] OP_CALL = 5'b01101;
   localparam logic [4:0] OP_RET  = 5'b01110;
   localparam logic [4:0] OP_LD   = 5'b01111;
   localparam logic [4:0] OP_ST   = 5'b10000;
   localparam logic [4:0] OP_SCR  = 5'b10001;
   localparam logic [4:0] OP_ENC  = 5'b10010;
   localparam logic [4:0] OP_DCR  = 5'b10011;
   localparam logic [4:0] OP_HLT  = 5'b11111;

   localparam logic [DW-1:0] SCR_K = {DW/2{2'b10}};
   localparam logic [DW-1:0] ENC_K = {DW/8{8'h3F}};

   logic [2:0]         state;
   logic [IMEM_AW-1:0] pc;
   logic [18:0]        ir;
   logic [SPW-1:0]     sp;
   logic [DW-1:0]      regs [16];
   logic [18:0]        imem [2**IMEM_AW];
   logic [DW-1:0]      dmem [2**DMEM_AW];
   logic [IMEM_AW-1:0] stk  [STACK_DEPTH];
   logic [DW-1:0]      dq, tq;

   logic [4:0]         op;
   logic [3:0]         rd, rs;
   logic [5:0]         f;
   logic [DW-1:0]      ra, rdv, bv, alu, xv;
   logic [IMEM_AW-1:0] sxi, pc1, npc;
   logic [DMEM_AW-1:0] ma, xra, xwa, raddr;
   logic [SPW-2:0]     pop_i;
   logic               is_alu, is_mem, is_xf, legal;
   logic [1:0]         flt;

   assign op    = ir[18:14];
   assign rd    = ir[13:10];
   assign rs    = ir[9:6];
   assign f     = ir[5:0];
   assign ra    = regs[rs];
   assign rdv   = regs[rd];
   assign bv    = f[5] ? DW'(signed'(f[4:0])) : regs[f[3:0]];
   assign sxi   = IMEM_AW'(signed'(f));
   assign pc1   = pc + IMEM_AW'(1);
   assign ma    = DMEM_AW'(ra + DW'(signed'(f)));
   assign xra   = DMEM_AW'(ra);
   assign xwa   = DMEM_AW'(rdv);
   assign raddr = is_xf ? xra : ma;
   assign pop_i = sp[SPW-2:0] - (SPW-1)'(1);

   assign dbg_data = regs[dbg_addr];
   assign pc_o     = pc;
   assign halted   = (state == S_HALT);
   assign retired  = !reset &&
                     ((state == S_EXEC && flt == 2'd0 && op != OP_HLT &&
                       !is_mem && !is_xf) ||
                      (state == S_MEM && !is_xf) ||
                      state == S_MEM2);

   // Opcode decode and single-cycle ALU result
   always_comb begin
      alu    = '0;
      is_alu = 1'b0;
      is_mem = 1'b0;
      is_xf  = 1'b0;
      legal  = 1'b1;
      case (op)
         OP_ADD: begin is_alu = 1'b1; alu = ra + bv; end
         OP_SUB: begin is_alu = 1'b1; alu = ra - bv; end
`ifdef CPU19_MULDIV_EN
         OP_MUL: begin is_alu = 1'b1; alu = ra * bv; end
         OP_DIV: begin
            is_alu = 1'b1;
            alu    = (bv == '0) ? '1 : ra / bv;
         end
`endif
         OP_INC: begin is_alu = 1'b1; alu = rdv + DW'(1); end
         OP_DEC: begin is_alu = 1'b1; alu = rdv - DW'(1); end
         OP_AND: begin is_alu = 1'b1; alu = ra & bv; end
         OP_OR:  begin is_alu = 1'b1; alu = ra | bv; end
         OP_XOR: begin is_alu = 1'b1; alu = ra ^ bv; end
         OP_NOT: begin is_alu = 1'b1; alu = ~ra; end
         OP_JMP, OP_BEQ, OP_BNE, OP_CALL, OP_RET, OP_HLT: ;
         OP_LD, OP_ST: is_mem = 1'b1;
         OP_SCR, OP_ENC, OP_DCR: is_xf = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   // Abnormal-stop detection for the instruction in EXEC
   always_comb begin
      flt = 2'd0;
      if (!legal)
         flt = 2'd1;
      else if (op == OP_CALL && sp == SPW'(STACK_DEPTH))
         flt = 2'd2;
      else if (op == OP_RET && sp == '0)
         flt = 2'd3;
   end

   // Next pc for instructions that complete in EXEC
   always_comb begin
      npc = pc1;
      case (op)
         OP_JMP, OP_CALL: npc = ir[IMEM_AW-1:0];
         OP_BEQ: if (rdv == ra) npc = pc1 + sxi;
         OP_BNE: if (rdv != ra) npc = pc1 + sxi;
         OP_RET: npc = stk[pop_i];
         default: ;
      endcase
   end

   // Transform applied to the word read from dmem
   always_comb begin
      case (op)
         OP_SCR:  xv = dq ^ SCR_K;
         OP_ENC:  xv = dq + ENC_K;
         default: xv = dq - ENC_K;
      endcase
   end

   // Control FSM, pc, stack pointer, register file and fault status
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         pc         <= '0;
         ir         <= '0;
         sp         <= '0;
         tq         <= '0;
         fault      <= 1'b0;
         fault_code <= 2'd0;
         for (int i = 0; i < 16; i++) regs[i] <= '0;
      end else begin
         unique case (state)
            S_IDLE: if (run) state <= S_FETCH;
            S_FETCH: begin
               ir    <= imem[pc];
               state <= S_EXEC;
            end
            S_EXEC: begin
               if (flt != 2'd0) begin
                  state      <= S_HALT;
                  fault      <= 1'b1;
                  fault_code <= flt;
               end else if (op == OP_HLT) begin
                  state <= S_HALT;
               end else if (is_mem || is_xf) begin
                  state <= S_MEM;
               end else begin
                  pc    <= npc;
                  state <= S_FETCH;
                  if (is_alu) regs[rd] <= alu;
                  if (op == OP_CALL) sp <= sp + SPW'(1);
                  if (op == OP_RET) sp <= sp - SPW'(1);
               end
            end
            S_MEM: begin
               if (is_xf) begin
                  tq    <= xv;
                  state <= S_MEM2;
               end else begin
                  if (op == OP_LD) regs[rd] <= dq;
                  pc    <= pc1;
                  state <= S_FETCH;
               end
            end
            S_MEM2: begin
               pc    <= pc1;
               state <= S_FETCH;
            end
            S_HALT: ;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Instruction memory load port, only while the core is parked
   always_ff @(posedge clk) begin
      if (!reset && imem_we && (state == S_IDLE || state == S_HALT))
         imem[imem_waddr] <= imem_wdata;
   end

   // Data memory: registered read every cycle, ST and transform writes
   always_ff @(posedge clk) begin
      dq <= dmem[raddr];
      if (!reset && state == S_MEM && op == OP_ST)
         dmem[ma] <= rdv;
      if (!reset && state == S_MEM2)
         dmem[xwa] <= tq;
   end

   // Return-stack push on a successful CALL
   always_ff @(posedge clk) begin
      if (!reset && state == S_EXEC && op == OP_CALL && flt == 2'd0)
         stk[sp[SPW-2:0]] <= pc1;
   end
endmodule

// File: tb/tb_cpu19_mc_core.sv
// tb_cpu19_mc_core: directed programs with a retire-stream scoreboard.
// Expected retire pc/latency queued by stimulus, checked by a monitor.
module tb_cpu19_mc_core;
   logic        clk = 1'b0;
   logic        reset, run, imem_we;
   logic [7:0]  imem_waddr;
   logic [18:0] imem_wdata;
   logic [3:0]  dbg_addr;
   logic [15:0] dbg_data;
   logic [7:0]  pc_o;
   logic        retired, halted, fault;
   logic [1:0]  fault_code;

   cpu19_mc_core dut (
      .clk(clk), .reset(reset), .run(run), .imem_we(imem_we),
      .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .pc_o(pc_o),
      .retired(retired), .halted(halted), .fault(fault),
      .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, MUL = 5'b00010;
   localparam logic [4:0] DIV = 5'b00011, INC = 5'b00100, DEC = 5'b00101;
   localparam logic [4:0] AND = 5'b00110, OR = 5'b00111, XOR = 5'b01000;
   localparam logic [4:0] NOT = 5'b01001, JMP = 5'b01010, BEQ = 5'b01011;
   localparam logic [4:0] BNE = 5'b01100, CALL = 5'b01101, RET = 5'b01110;
   localparam logic [4:0] LD = 5'b01111, ST = 5'b10000, SCR = 5'b10001;
   localparam logic [4:0] ENC = 5'b10010, DCR = 5'b10011, HLT = 5'b11111;

   typedef struct {
      logic [7:0] pc;
      int         lat;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       e;
   int         n_cmp = 0, n_bad = 0, cyc = 0, last = 0, cur = 0;
   logic       pend = 1'b0;
   logic [7:0] pend_pc;

   function automatic logic [18:0] I(logic [4:0] o, logic [3:0] d,
                                     logic [3:0] s, logic [5:0] ff);
      return {o, d, s, ff};
   endfunction

   function automatic logic [18:0] J(logic [4:0] o, logic [7:0] t);
      return {o, 6'd0, t};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every retire pops one record; pc checked a cycle later
   always @(negedge clk) begin
      cyc++;
      if (pend) begin
         chk("ret_pc", {24'd0, pc_o}, {24'd0, pend_pc});
         pend = 1'b0;
      end
      if (run === 1'b1) last = cyc;
      if (retired === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("ret_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("ret_lat", cyc - last, e.lat);
            pend_pc = e.pc;
            pend    = 1'b1;
         end
         last = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      exp_q.delete();
      cur = 0;
   endtask

   task automatic wr(int a, logic [18:0] w);
      imem_we    = 1'b1;
      imem_waddr = a[7:0];
      imem_wdata = w;
      tick();
      imem_we = 1'b0;
   endtask

   task automatic expect_ret(int p, int lat);
      exp_q.push_back('{pc: p[7:0], lat: lat});
   endtask

   task automatic emit(logic [18:0] w, int lat);
      wr(cur, w);
      expect_ret(cur + 1, lat);
      cur++;
   endtask

   // Builds a 16-bit constant nibble by nibble with doubling ADDs
   task automatic ld_const(logic [3:0] r, logic [15:0] v);
      logic [3:0] nib;
      nib = v[15:12];
      emit(I(ADD, r, 4'd0, {2'b10, nib}), 2);
      for (int k = 2; k >= 0; k--) begin
         for (int d = 0; d < 4; d++) emit(I(ADD, r, r, {2'b00, r}), 2);
         nib = v[k*4 +: 4];
         emit(I(ADD, r, r, {2'b10, nib}), 2);
      end
   endtask

   task automatic go();
      run = 1'b1;
      tick();
      run = 1'b0;
   endtask

   task automatic wait_halt();
      int n = 0;
      while (halted !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      chk("halt_reached", {31'd0, halted}, 32'd1);
      tick();
      tick();
   endtask

   task automatic chk_reg(string nm, logic [3:0] r, logic [15:0] v);
      dbg_addr = r;
      #1;
      chk(nm, {16'd0, dbg_data}, {16'd0, v});
   endtask

   task automatic chk_end(logic f, logic [1:0] fc);
      chk("halted", {31'd0, halted}, 32'd1);
      chk("fault", {31'd0, fault}, {31'd0, f});
      chk("fault_code", {30'd0, fault_code}, {30'd0, fc});
      chk("queue_empty", exp_q.size(), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; run = 1'b0; imem_we = 1'b0;
      imem_waddr = '0; imem_wdata = '0; dbg_addr = '0;
      do_reset();
      chk("rst_pc", {24'd0, pc_o}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_fault", {29'd0, fault, fault_code}, 32'd0);
      chk("rst_retired", {31'd0, retired}, 32'd0);
      chk_reg("rst_r1", 4'd1, 16'h0000);

      // Arithmetic: ADD, ADD negative immediate, SUB register
      emit(I(ADD, 4'd1, 4'd0, 6'b100101), 2);
      emit(I(ADD, 4'd2, 4'd1, 6'b111101), 2);
      emit(I(SUB, 4'd3, 4'd1, 6'b000010), 2);
      wr(cur, J(HLT, 8'd0));
      go();
      wait_halt();
      chk_reg("arith_r1", 4'd1, 16'd5);
      chk_reg("arith_r2", 4'd2, 16'd2);
      chk_reg("arith_r3", 4'd3, 16'd3);
      chk_end(1'b0, 2'd0);

      // Remaining ALU ops
      do_reset();
      emit(I(ADD, 4'd1, 4'd0, 6'b100101), 2);
      emit(I(ADD, 4'd2, 4'd0, 6'b100011), 2);
      emit(I(INC, 4'd3, 4'd0, 6'b000000), 2);
      emit(I(DEC, 4'd4, 4'd0, 6'b000000), 2);
      emit(I(AND, 4'd5, 4'd1, 6'b100110), 2);
      emit(I(OR, 4'd6, 4'd1, 6'b000010), 2);
      emit(I(XOR, 4'd7, 4'd1, 6'b111111), 2);
      emit(I(NOT, 4'd8, 4'd2, 6'b000000), 2);
      wr(cur, J(HLT, 8'd0));
      go();
      wait_halt();
      chk_reg("inc", 4'd3, 16'h0001);
      chk_reg("dec", 4'd4, 16'hFFFF);
      chk_reg("and", 4'd5, 16'h0004);
      chk_reg("or", 4'd6, 16'h0007);
      chk_reg("xor", 4'd7, 16'hFFFA);
      chk_reg("not", 4'd8, 16'hFFFC);
      chk_end(1'b0, 2'd0);

      // BEQ taken backwards from pc 10 to 9
      do_reset();
      wr(0, I(ADD, 4'd1, 4'd0, 6'b100111)); expect_ret(1, 2);
      wr(1, I(ADD, 4'd2, 4'd0, 6'b100111)); expect_ret(2, 2);
      wr(2, J(JMP, 8'd10));                 expect_ret(10, 2);
      wr(10, I(BEQ, 4'd1, 4'd2, 6'b111110)); expect_ret(9, 2);
      wr(9, J(HLT, 8'd0));
      go();
      wait_halt();
      chk_end(1'b0, 2'd0);

      // BNE not taken falls through to 11
      do_reset();
      wr(10, I(BNE, 4'd1, 4'd2, 6'b111110));
      wr(11, J(HLT, 8'd0));
      expect_ret(1, 2); expect_ret(2, 2);
      expect_ret(10, 2); expect_ret(11, 2);
      go();
      wait_halt();
      chk_end(1'b0, 2'd0);

      // Branch from 255 with +1 wraps to 1
      do_reset();
      wr(0, J(JMP, 8'd255));                 expect_ret(255, 2);
      wr(255, I(BEQ, 4'd0, 4'd0, 6'b000001)); expect_ret(1, 2);
      wr(1, J(HLT, 8'd0));
      go();
      wait_halt();
      chk_end(1'b0, 2'd0);

      // ST/LD with offset +2
      do_reset();
      ld_const(4'd4, 16'hBEEF);
      ld_const(4'd5, 16'h0010);
      emit(I(ST, 4'd4, 4'd5, 6'b000010), 3);
      emit(I(LD, 4'd6, 4'd5, 6'b000010), 3);
      wr(cur, J(HLT, 8'd0));
      go();
      wait_halt();
      chk("dmem_12", {16'd0, dut.dmem[8'h12]}, 32'h0000BEEF);
      chk_reg("ld_r6", 4'd6, 16'hBEEF);
      chk_end(1'b0, 2'd0);

      // Transforms ENC, DCR, SCR
      do_reset();
      ld_const(4'd1, 16'h1234);
      emit(I(ADD, 4'd3, 4'd0, 6'b100011), 2);
      emit(I(ADD, 4'd2, 4'd0, 6'b101000), 2);
      emit(I(ST, 4'd1, 4'd3, 6'b000000), 3);
      emit(I(ENC, 4'd2, 4'd3, 6'b000000), 4);
      emit(I(LD, 4'd5, 4'd2, 6'b000000), 3);
      emit(I(DCR, 4'd2, 4'd2, 6'b000000), 4);
      emit(I(LD, 4'd6, 4'd2, 6'b000000), 3);
      emit(I(SCR, 4'd2, 4'd3, 6'b000000), 4);
      emit(I(LD, 4'd7, 4'd2, 6'b000000), 3);
      wr(cur, J(HLT, 8'd0));
      go();
      wait_halt();
      chk_reg("enc", 4'd5, 16'h5173);
      chk_reg("dcr", 4'd6, 16'h1234);
      chk_reg("scr", 4'd7, 16'hB89E);
      chk_end(1'b0, 2'd0);

      // 16 nested CALLs succeed, the 17th overflows
      do_reset();
      for (int i = 0; i < 16; i++) begin
         wr(i, J(CALL, 8'(i + 1)));
         expect_ret(i + 1, 2);
      end
      wr(16, J(CALL, 8'd17));
      go();
      wait_halt();
      chk_end(1'b1, 2'd2);
      chk("ovf_sp", {27'd0, dut.sp}, 32'd16);
      chk("ovf_pc", {24'd0, pc_o}, 32'd16);

      // Lone RET underflows
      do_reset();
      chk("rst_sp", {27'd0, dut.sp}, 32'd0);
      wr(0, J(RET, 8'd0));
      go();
      wait_halt();
      chk_end(1'b1, 2'd3);
      chk("udf_pc", {24'd0, pc_o}, 32'd0);

      // Reset during the transform write cycle
      do_reset();
      wr(0, I(ADD, 4'd2, 4'd0, 6'b101000)); expect_ret(1, 2);
      wr(1, I(ADD, 4'd3, 4'd0, 6'b100011)); expect_ret(2, 2);
      wr(2, I(ENC, 4'd2, 4'd3, 6'b000000));
      wr(3, J(HLT, 8'd0));
      go();
      repeat (7) tick();
      chk("in_mem2", {29'd0, dut.state}, 32'd4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_dmem8", {16'd0, dut.dmem[8]}, 32'h0000B89E);
      chk("mid_idle", {29'd0, dut.state}, 32'd0);
      chk("mid_pc", {24'd0, pc_o}, 32'd0);
      chk_reg("mid_r2", 4'd2, 16'h0000);
      chk("mid_queue", exp_q.size(), 32'd0);
      expect_ret(1, 2); expect_ret(2, 2); expect_ret(3, 4);
      go();
      wait_halt();
      chk("rerun_dmem8", {16'd0, dut.dmem[8]}, 32'h00005173);
      chk_end(1'b0, 2'd0);

      // MUL/DIV: implemented or illegal depending on the build
      do_reset();
`ifdef CPU19_MULDIV_EN
      emit(I(ADD, 4'd1, 4'd0, 6'b100110), 2);
      emit(I(MUL, 4'd2, 4'd1, 6'b100111), 2);
      emit(I(DIV, 4'd3, 4'd2, 6'b100101), 2);
      emit(I(DIV, 4'd4, 4'd2, 6'b000000), 2);
      wr(cur, J(HLT, 8'd0));
      go();
      wait_halt();
      chk_reg("mul", 4'd2, 16'd42);
      chk_reg("div", 4'd3, 16'd8);
      chk_reg("div0", 4'd4, 16'hFFFF);
      chk_end(1'b0, 2'd0);
`else
      wr(0, I(MUL, 4'd1, 4'd0, 6'b100010));
      go();
      wait_halt();
      chk_end(1'b1, 2'd1);
      chk_reg("mul_r1", 4'd1, 16'h0000);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cpu19_mc_core.md
# cpu19_mc_core

Parametrised multi-cycle successor to the 19-bit CPU. It keeps the 19-bit instruction format and the 16-entry register file, and makes data width, memory depths and stack depth configurable. It adds an explicit fetch/execute/memory state machine, PC-relative branches, stack overflow/underflow detection with fault reporting, a HALT instruction, and an instruction-memory load port. It sits at the top of the compute subsystem and owns its own instruction memory, data memory and return stack.

## Interface
- DW, 16, data/register width; multiple of 8, ≥ 16
- IMEM_AW, 8, instruction memory address width (depth 2^IMEM_AW × 19 bits); ≤ 14
- DMEM_AW, 8, data memory address width (depth 2^DMEM_AW × DW)
- STACK_DEPTH, 16, return-stack entries; power of 2

Ports:
- clk  in  1  single clock; everything on rising edge
- reset  in  1  synchronous, active-high
- run  in  1  start execution from IDLE
- imem_we  in  1  instruction-memory write strobe; honoured only in IDLE or HALT
- imem_waddr  in  IMEM_AW  write address
- imem_wdata  in  19  instruction word
- dbg_addr  in  4  register-file debug select
- dbg_data  out  DW  combinational r[dbg_addr]
- pc_o  out  IMEM_AW  current PC
- retired  out  1  one-cycle pulse per retired instruction
- halted  out  1  core is in HALT
- fault  out  1  sticky; set together with halted on an abnormal stop
- fault_code  out  2  0 none, 1 illegal opcode, 2 stack overflow, 3 stack underflow

## Operation
- Instruction fields: op = ins[18:14], rd = [13:10], rs = [9:6], f = [5:0].
- Operand B: if f[5] = 1, B = sign-extend(f[4:0]) to DW; else B = r[f[3:0]]. sx6 = sign-extend(f) to IMEM_AW/DMEM_AW.
- ALU ops:
  - 00000 ADD: rd = rs + B
  - 00001 SUB: rd = rs − B
  - 00010 MUL: rd = low DW bits of rs × B
  - 00011 DIV: rd = rs / B, unsigned; B = 0 gives all ones
  - 00100 INC: rd + 1
  - 00101 DEC: rd − 1
  - 00110 AND, 00111 OR, 01000 XOR: rs op B
  - 01001 NOT: ~rs
  - All ALU results wrap modulo 2^DW.
- Control ops:
  - 01010 JMP: pc = ins[IMEM_AW-1:0].
  - 01011 BEQ / 01100 BNE: compare r[rd] with r[rs]; if taken, pc = pc + 1 + sx6, wrapping modulo 2^IMEM_AW.
  - 01101 CALL: push pc + 1, sp++, pc = ins[IMEM_AW-1:0].
  - 01110 RET: sp−−, pc = stack[sp].
- Memory ops, with address A = r[rs] + sx6, truncated to DMEM_AW:
  - 01111 LD: rd = dmem[A].
  - 10000 ST: dmem[A] = r[rd].
- Transform ops, read dmem[r[rs]] and write dmem[r[rd]] (addresses truncated):
  - 10001 SCR: XOR with {DW/2{2'b10}}.
  - 10010 ENC: + {DW/8{8'h3F}}.
  - 10011 DCR: − the same constant.
- 11111 HALT: stop, fault stays 0.
- Any other opcode: illegal → fault_code 1.
- Stack: overflow is CALL when sp = STACK_DEPTH (fault 2). Underflow is RET when sp = 0 (fault 3). On either, the push/pop is suppressed and pc is not updated.
- State machine:
  - IDLE → FETCH when run = 1.
  - FETCH: IR ← imem[pc] → EXEC.
  - EXEC: ALU writeback or branch resolve, then retire and go to FETCH. LD/ST/transform go to MEM.
  - MEM: LD writeback or ST write, retire → FETCH. Transform latches the read → MEM2.
  - MEM2: transform write, retire → FETCH.
  - HALT: terminal until reset.
- Non-branching instructions advance pc by 1 modulo 2^IMEM_AW.
- imem_we outside IDLE/HALT is ignored.
- Reset values: pc, sp, all 16 registers, IR and all outputs are 0; state is IDLE. imem and dmem contents are preserved across reset.

## Timing
- ALU, jump, branch, CALL, RET: 2 cycles (FETCH, EXEC).
- LD, ST: 3 cycles. Transforms: 4 cycles.
- dmem read is synchronous, 1-cycle latency; data is used in the cycle after the address is presented.
- retired pulses in the final cycle of each instruction. HALT and faulting instructions do not pulse retired.
- halted and fault are visible the cycle after the EXEC that detects the condition.
- imem write takes effect the next cycle. A write and run asserted in the same IDLE cycle: the write completes, and the FETCH in the next cycle sees the new word.
- Reset asserted in any state aborts the instruction in flight. No partial register or memory write is committed in the reset cycle.

## Configuration
- CPU19_MULDIV_EN defined: MUL and DIV are implemented as above, single-cycle combinational in EXEC.
- Not defined: opcodes 00010 and 00011 decode as illegal and raise fault_code 1. No multiplier or divider is instantiated.

## Test plan
- Arithmetic: load ADD r1,r0,#5; ADD r2,r1,#−3; SUB r3,r1,r2; HALT; pulse run. Required: r1=5, r2=2, r3=3, halted=1, fault=0, retired pulses 3 times, 2 cycles apart.
- Branch: r1=r2=7, BEQ f=−2 at pc 10. Required: pc becomes 9. With BNE, pc becomes 11. Branch from pc 255 with f=+1 wraps pc to 1.
- Memory: ST r4=0xBEEF at r5=0x10 with f=+2, then LD r6 from the same address. Required: dmem[0x12]=0xBEEF, r6=0xBEEF, each instruction takes 3 cycles.
- Transforms: dmem[3]=0x1234, ENC rd→8, rs→3. Required: dmem[8]=0x5173. DCR back gives 0x1234. SCR gives 0xB89E.
- Stack: 16 nested CALLs then a 17th. Required: fault_code 2, halted, sp=16. After reset, a lone RET gives fault_code 3.
- Mid-run reset and option: reset during MEM2. Required: target dmem unchanged, state IDLE, program still present. Without CPU19_MULDIV_EN, MUL gives fault_code 1.
